inscache: RTL
=============

# inscache

Direct-mapped, read-only instruction cache between the memory controller and the instruction-fetch stage. Every cycle it answers the fetch stage's request for the 32 bits at the current PC, which may be only halfword aligned because the design supports RVC. On a miss it refills whole 16-byte lines from the memory controller one word at a time. The hit path is combinational, so the fetch stage sustains one instruction per cycle on hits.

## Interface
Parameters:
- `IDX_W`, default 6: index width. The cache has 2^IDX_W lines of 16 bytes; tag = addr[31:4+IDX_W].

Ports:
- `clk_in`  in  1  clock.
- `rst_in`  in  1  reset; synchronous, active-high.
- `rdy_in`  in  1  global ready; when low all state freezes and `mem_ask` holds its value.
- `in_PC`  in  32  fetch address from the fetch stage (bit 0 always 0).
- `ask_for`  in  1  fetch stage requests the instruction at `in_PC`.
- `give_you`  out  1  `g_ins` is valid for `in_PC` this cycle (combinational).
- `g_ins`  out  32  {halfword@PC+2, halfword@PC}.
- `mem_ask`  out  1  word read request to the memory controller (registered).
- `mem_addr`  out  32  word-aligned read address (registered).
- `mem_done`  in  1  one-cycle pulse: `mem_data` holds the word at `mem_addr`.
- `mem_data`  in  32  returned word, little-endian.

## Operation
- Storage per line: valid bit, tag, 8 halfwords.
- Address fields: halfword select = addr[3:1]; index = addr[3+IDX_W:4].
- Lookup: lo = line of `in_PC`; hi = line of `in_PC+2` (32-bit wrap).
  - hit_lo = valid and tag match for lo; hit_hi likewise for hi.
  - hi and lo are the same line unless addr[3:1]==7.
- Compressed: halfword@PC[1:0] != 2'b11.
- `give_you` = state==IDLE && `ask_for` && hit_lo && (compressed || hit_hi) && !`rst_in`.
- `g_ins`[15:0] = halfword@PC.
- `g_ins`[31:16] = halfword@PC+2 if hit_hi, else 16'h0. The 16'h0 case is only reachable when the low halfword is compressed.
- `g_ins` is don't-care when `give_you`=0.
- FSM states:
  - IDLE
    - With `ask_for`: if !hit_lo, latch fill_addr = line base of lo and go to REQ, cnt=0.
    - Else if !compressed && !hit_hi, latch line base of hi and go to REQ.
    - Otherwise stay in IDLE.
    - A compressed instruction never triggers a refill of hi.
  - REQ
    - `mem_ask`=1, `mem_addr`=fill_addr+4*cnt.
    - On `mem_done`: write `mem_data` into halfwords 2cnt and 2cnt+1 of the target line, then go to GAP.
    - If cnt==3, also write the tag, set valid, and go to IDLE instead.
  - GAP: `mem_ask`=0 for one cycle, cnt++, then back to REQ.
- A line's valid bit is cleared on the first word write of its refill, so a partially filled line never hits.
- No flush input. A pipeline clear in the fetch stage only changes `in_PC`, and an in-flight refill always completes. The fetch stage ignores `give_you` during its clear cycle.

## Timing
- Reset:
  - all valid bits = 0; state IDLE; cnt=0.
  - `mem_ask`=0, `mem_addr`=0.
  - `give_you`=0 during reset.
  - Reset mid-refill abandons it; `mem_ask` is low the cycle after reset is sampled.
- Hit latency: 0 cycles (same cycle as `ask_for`).
- Miss:
  - `mem_ask` rises the cycle after the miss is seen.
  - Each word costs the controller latency plus 1 GAP cycle.
  - `give_you` for the refilled line comes at the earliest in the cycle after the 4th `mem_done`.
- Line-crossing miss on both lines: lo is refilled first, then hi, as two back-to-back refills separated by one IDLE cycle.
- `mem_addr` is stable while `mem_ask`=1. `mem_done` arriving while `mem_ask`=0 is ignored.
- `rdy_in`=0: FSM, counters, and arrays hold. `give_you` is still evaluated combinationally; the fetch stage also gates on `rdy_in`.
- `ask_for` dropping during a refill has no effect; the refill completes.

## Structure
- Shared `const.v`: line-size and offset-width defines, and the halfword-select macro. The RVC test (bits[1:0]!=2'b11) is shared with the fetch stage and decoder.
- One natural sub-module: `ic_line_ram` holds the tag/valid/data arrays. It has two combinational read ports (lo, hi) and one halfword-pair write port. The FSM stays in `inscache`.

## Test plan
- Cold miss, PC=0x0, memory words 0x00000013 at 0x0, 0x4, 0x8, 0xC: four REQ/done pairs at 0x0, 0x4, 0x8, 0xC, each followed by one low `mem_ask` cycle. The next cycle gives `give_you`=1, `g_ins`=0x00000013.
- After that fill, PC=0x4 then 0x8 on consecutive cycles: `give_you`=1 both cycles, no `mem_ask`.
- PC=0xE with halfwords 0x0513@0xE and 0x0ff0@0x10 (line 0x10 invalid): one refill at 0x10–0x1C, then `g_ins`=0x0ff00513.
- PC=0xE with compressed 0x4501 and line 0x10 invalid: `give_you`=1 immediately, `g_ins`=0x00004501, no refill.
- IDX_W=6, line 0x0 valid, PC=0x400: index aliases to 0, tag differs. Result is a miss, a refill from 0x400, and a subsequent PC=0x0 misses again.
- Assert `rst_in` after the 2nd `mem_done` of a refill: `mem_ask`=0 next cycle, and PC=0x0 then misses with a full 4-word refill.

Source files
------------

// File: rtl/inscache_pkg.sv
// Shared constants for the instruction cache: line geometry, FSM encodings
// and the RVC length test that the fetch stage and decoder also use.
package inscache_pkg;
  localparam int LINE_OFF_W  = 4;
  localparam int HW_PER_LINE = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [1:0] LAST_WORD = 2'd3;

  // A 16-bit parcel is a compressed instruction unless its low two bits are 11.
  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/ic_line_ram.sv
// Tag/valid/data storage for the instruction cache: two combinational
// halfword read ports (lo, hi) and one halfword-pair write port for refills.
module ic_line_ram
  import inscache_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:1] i_lo_addr,
  input  logic [31:1] i_hi_addr,
  output logic        o_lo_hit,
  output logic        o_hi_hit,
  output logic [15:0] o_lo_hw,
  output logic [15:0] o_hi_hw,
  input  logic        i_wr_en,
  input  logic [31:2] i_wr_addr,
  input  logic [31:0] i_wr_data
);
  localparam int LINES   = 1 << IDX_W;
  localparam int TAG_LSB = LINE_OFF_W + IDX_W;
  localparam int TAG_W   = 32 - TAG_LSB;

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [15:0]      r_data [LINES][HW_PER_LINE];

  logic [IDX_W-1:0] w_lo_idx;
  logic [IDX_W-1:0] w_hi_idx;
  logic [IDX_W-1:0] w_wr_idx;
  logic [1:0]       w_wr_pair;

  assign w_lo_idx  = i_lo_addr[LINE_OFF_W +: IDX_W];
  assign w_hi_idx  = i_hi_addr[LINE_OFF_W +: IDX_W];
  assign w_wr_idx  = i_wr_addr[LINE_OFF_W +: IDX_W];
  assign w_wr_pair = i_wr_addr[3:2];

  assign o_lo_hit = r_valid[w_lo_idx] && (r_tag[w_lo_idx] == i_lo_addr[31:TAG_LSB]);
  assign o_hi_hit = r_valid[w_hi_idx] && (r_tag[w_hi_idx] == i_hi_addr[31:TAG_LSB]);
  assign o_lo_hw  = r_data[w_lo_idx][i_lo_addr[3:1]];
  assign o_hi_hw  = r_data[w_hi_idx][i_hi_addr[3:1]];

  // The first word of a refill invalidates the line so a half-filled line
  // never hits; the last word revalidates it together with the new tag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      if (w_wr_pair == LAST_WORD) begin
        r_valid[w_wr_idx] <= 1'b1;
      end else if (w_wr_pair == 2'd0) begin
        r_valid[w_wr_idx] <= 1'b0;
      end
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone decide
  // hits, and a reset-free array can map onto plain RAM.
  always_ff @(posedge clk_in) begin
    if (i_wr_en) begin
      r_data[w_wr_idx][{w_wr_pair, 1'b0}] <= i_wr_data[15:0];
      r_data[w_wr_idx][{w_wr_pair, 1'b1}] <= i_wr_data[31:16];
      if (w_wr_pair == LAST_WORD) begin
        r_tag[w_wr_idx] <= i_wr_addr[31:TAG_LSB];
      end
    end
  end
endmodule

// File: rtl/inscache.sv
// Direct-mapped read-only instruction cache: combinational hit path for
// halfword-aligned fetches, word-at-a-time refill of 16-byte lines on a miss.
module inscache
  import inscache_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] in_PC,
  input  logic        ask_for,
  output logic        give_you,
  output logic [31:0] g_ins,
  output logic        mem_ask,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);
  logic [1:0]  r_state;
  logic [1:0]  r_cnt;
  logic [31:4] r_fill_line;
  logic        r_mem_ask;
  logic [31:0] r_mem_addr;

  logic [31:1] w_hi_pc;
  logic        w_lo_hit;
  logic        w_hi_hit;
  logic [15:0] w_lo_hw;
  logic [15:0] w_hi_hw;
  logic        w_rvc;
  logic        w_wr_en;
  logic [1:0]  w_cnt_nxt;
  logic        w_unused_pc0;

  // Halfword address of PC+2, wrapping at 2^32.
  assign w_hi_pc      = in_PC[31:1] + 31'd1;
  assign w_unused_pc0 = in_PC[0];
  assign w_cnt_nxt    = r_cnt + 2'd1;
  assign w_rvc        = is_rvc(w_lo_hw);
  assign w_wr_en      = rdy_in && !rst_in && (r_state == ST_REQ) && mem_done;

  ic_line_ram #(
    .IDX_W (IDX_W)
  ) u_line_ram (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .i_lo_addr (in_PC[31:1]),
    .i_hi_addr (w_hi_pc),
    .o_lo_hit  (w_lo_hit),
    .o_hi_hit  (w_hi_hit),
    .o_lo_hw   (w_lo_hw),
    .o_hi_hw   (w_hi_hw),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_mem_addr[31:2]),
    .i_wr_data (mem_data)
  );

  assign give_you = (r_state == ST_IDLE) && ask_for && w_lo_hit
                    && (w_rvc || w_hi_hit) && !rst_in;
  assign g_ins    = {(w_hi_hit ? w_hi_hw : 16'h0), w_lo_hw};
  assign mem_ask  = r_mem_ask;
  assign mem_addr = r_mem_addr;

  // NOTE: state registers use non-blocking assignments so every branch sees
  // the pre-edge values of r_cnt/r_state regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 2'd0;
      r_fill_line <= '0;
      r_mem_ask   <= 1'b0;
      r_mem_addr  <= '0;
    end else if (rdy_in) begin
      case (r_state)
        ST_IDLE: begin
          if (ask_for && !w_lo_hit) begin
            r_fill_line <= in_PC[31:4];
            r_mem_addr  <= {in_PC[31:4], 4'h0};
            r_cnt       <= 2'd0;
            r_mem_ask   <= 1'b1;
            r_state     <= ST_REQ;
          end else if (ask_for && !w_rvc && !w_hi_hit) begin
            r_fill_line <= w_hi_pc[31:4];
            r_mem_addr  <= {w_hi_pc[31:4], 4'h0};
            r_cnt       <= 2'd0;
            r_mem_ask   <= 1'b1;
            r_state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_done) begin
            r_mem_ask <= 1'b0;
            if (r_cnt == LAST_WORD) begin
              r_cnt   <= 2'd0;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          r_cnt      <= w_cnt_nxt;
          r_mem_addr <= {r_fill_line, w_cnt_nxt, 2'b00};
          r_mem_ask  <= 1'b1;
          r_state    <= ST_REQ;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_ask <= 1'b0;
        end
      endcase
    end
  end
endmodule
